fsqrt_arbiter: RTL and testbench
================================

Name: fsqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Floating_Sqrt datapath (ports clk, EN, A[31:0], result[31:0]) between N_REQ requesters.
- Accepts IEEE-754 single-precision operands over per-requester valid/ready handshakes and drives EN/A of the shared unit.
- Returns each result to the requester that issued it.
- Negative non-zero operands bypass the unit and return a canonical NaN with identical latency.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SQRT_LAT, 2, clock edges from the issue edge to a valid Floating_Sqrt result (≥1).
- PIPELINED, 1, 1 = unit accepts one operand per cycle; 0 = one operation in flight at a time.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  32*N_REQ  operands; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs on valid&ready.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  3  requester index of the current rsp_data.
- rsp_data  out  32  sqrt result, or NaN for negative input.
- sqrt_en  out  1  drives EN of the shared unit.
- sqrt_a  out  32  drives A of the shared unit.
- sqrt_result  in  32  result of the shared unit.

Behaviour:
- Reset values (async, rst_n=0): req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, sqrt_en=0, sqrt_a=0.
  - Round-robin pointer = 0; tag pipeline cleared; FSM = IDLE.
  - All in-flight operations are discarded; no rsp_valid is produced for them after reset release.
- Arbitration (combinational from registered pointer):
  - Winner = first i with req_valid[i]=1, searching from ptr upward with wrap at N_REQ-1 -> 0.
  - req_ready is one-hot on the winner only when issue is allowed.
  - On a transfer, ptr <= winner+1 (mod N_REQ).
  - No valid requests: ptr holds.
- Issue allowed:
  - PIPELINED=1: every cycle.
  - PIPELINED=0: only in IDLE.
- Issue edge:
  - sqrt_a <= operand; sqrt_en <= 1 for exactly that cycle, else 0; sqrt_a holds its last value.
  - Tag {valid=1, id, byp} enters stage 0 of a SQRT_LAT-deep shift register; stages shift every cycle.
  - Empty issue cycles insert valid=0.
- Bypass rule: byp=1 when operand[31]=1 and operand[30:0]≠0.
  - Such operands still occupy their issue slot; sqrt_en=0 for that slot.
  - Response data = 32'h7FC00000.
  - -0.0 (32'h80000000) is not bypassed and goes to the unit.
- Response: when the last tag stage has valid=1, the outputs are registered on the next edge:
  - rsp_valid=1; rsp_id=tag.id;
  - rsp_data = byp ? 32'h7FC00000 : sqrt_result.
- Total latency: request transfer edge to rsp_valid high = SQRT_LAT+1 edges, fixed, independent of contention.
- There is no response backpressure; requesters must sink rsp_valid pulses.
- FSM (PIPELINED=0 only):
  - IDLE -> BUSY on transfer.
  - BUSY holds, with a down-counter loaded with SQRT_LAT-1 and decremented each cycle; -> DONE when the counter is 0.
  - DONE -> IDLE after one cycle (rsp_valid registered). A new transfer is allowed from IDLE on the cycle after DONE.
  - PIPELINED=1: FSM held in IDLE.
- Simultaneous events:
  - All N_REQ valid: each requester is granted once per N_REQ transfers.
  - A requester whose req_valid drops before grant is skipped without penalty.
  - req_data must be held stable while req_valid=1 and req_ready=0.
- Reset asserted mid-operation: outputs return to reset values immediately (async); the tag pipeline is flushed.

Decomposition:
- Shared package fsqrt_pkg holds:
  - constant QNAN = 32'h7FC00000;
  - tag struct {valid, id[2:0], byp};
  - function is_neg_nonzero.
- One sub-module: rr_arbiter (N_REQ-wide round-robin picker with pointer register and enable).
- Tag shift register and FSM stay in the top module.

Test Plan:
- Single requester 0 sends 32'h41C80000 (25) -> rsp_valid after SQRT_LAT+1 edges, rsp_id=0, rsp_data=32'h40A00000 (5.0).
- All 4 requesters hold valid continuously with 32'h41800000 (16), 32'h42C80000 (100), 32'h3F800000 (1), 32'h40800000 (4), PIPELINED=1.
  - Grants in order 0,1,2,3,0...
  - Back-to-back responses 32'h40800000, 32'h41200000, 32'h3F800000, 32'h40000000, with matching rsp_id.
- Requester 2 sends 32'hC0800000 (-4) -> sqrt_en stays 0 in that slot; rsp_data=32'h7FC00000, rsp_id=2, same latency.
- Requester 1 sends 32'h80000000 (-0.0) -> issued to the unit; rsp_data equals sqrt_result for that slot.
- PIPELINED=0, requesters 0 and 1 valid together:
  - Second req_ready is held low until FSM returns to IDLE.
  - Issue spacing is SQRT_LAT+2 cycles.
  - Both responses are correct.
- rst_n pulsed low with 2 operations in flight -> all outputs 0 immediately; no rsp_valid after release; next grant goes to requester 0.

Source files
------------

// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the shared square-root arbiter.
package fsqrt_pkg;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
        logic       byp;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // -0.0 has a defined square root and still goes to the unit
    function automatic logic is_neg_nonzero(input logic [31:0] f);
        return f[31] && (f[30:0] != 31'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts at the registered pointer and wraps;
// the pointer advances past the winner only when a grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_id,
    output logic             any
);

    logic [2:0] ptr_reg;
    logic [7:0] req_ext;

    assign req_ext = 8'(req);

    always_comb begin
        int         idx;
        logic [2:0] idx3;
        any      = 1'b0;
        grant_id = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx3 = 3'(idx);
            if (!any && req_ext[idx3]) begin
                any      = 1'b1;
                grant_id = idx3;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = en && any && (grant_id == 3'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 3'd0;
        end else if (en && any) begin
            ptr_reg <= (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
        end
    end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Shares one Floating_Sqrt unit between N_REQ requesters; results return with
// a fixed latency, tagged with the issuing requester's index.
module fsqrt_arbiter
    import fsqrt_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int SQRT_LAT  = 2,
    parameter int PIPELINED = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 sqrt_en,
    output logic [31:0]          sqrt_a,
    input  logic [31:0]          sqrt_result
);

    localparam int CNT_W = (SQRT_LAT > 1) ? $clog2(SQRT_LAT) : 1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    tag_t             tag_reg [SQRT_LAT];
    tag_t             tag_last;
    logic [31:0]      ops [8];
    logic [31:0]      operand;
    logic [2:0]       win_id;
    logic             win_any;
    logic             issue_ok;
    logic             issue;
    logic             byp;

    // Gating with rst_n keeps req_ready low for the whole reset assertion
    assign issue_ok = rst_n && ((PIPELINED != 0) || (state_reg == IDLE));
    assign issue    = issue_ok && win_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .en       (issue_ok),
        .grant    (req_ready),
        .grant_id (win_id),
        .any      (win_any)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_ops
        if (gi < N_REQ) begin : g_used
            assign ops[gi] = req_data[32*gi +: 32];
        end else begin : g_pad
            assign ops[gi] = 32'd0;
        end
    end

    assign operand  = ops[win_id];
    assign byp      = is_neg_nonzero(operand);
    assign tag_last = tag_reg[SQRT_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg[0] <= '0;
        end else begin
            tag_reg[0] <= issue ? tag_t'{valid: 1'b1, id: win_id, byp: byp} : '0;
        end
    end

    for (genvar gi = 1; gi < SQRT_LAT; gi++) begin : g_tag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_reg[gi] <= '0;
            end else begin
                tag_reg[gi] <= tag_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sqrt_en   <= 1'b0;
            sqrt_a    <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 3'd0;
            rsp_data  <= 32'd0;
        end else begin
            sqrt_en   <= issue && !byp;
            if (issue) begin
                sqrt_a <= operand;
            end
            rsp_valid <= tag_last.valid;
            if (tag_last.valid) begin
                rsp_id   <= tag_last.id;
                rsp_data <= tag_last.byp ? QNAN : sqrt_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Single-issue mode: the DONE cycle separates the response from the next grant
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (issue && (PIPELINED == 0)) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(SQRT_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Bench for fsqrt_arbiter: a pipelined and a single-issue instance driven side by side.
module tb_fsqrt_arbiter;
    import fsqrt_pkg::*;

    localparam int N_REQ    = 4;
    localparam int SQRT_LAT = 2;   // the unit model below has one register stage

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid   [2];
    logic [32*N_REQ-1:0]  req_data    [2];
    logic [N_REQ-1:0]     req_ready   [2];
    logic                 rsp_valid   [2];
    logic [2:0]           rsp_id      [2];
    logic [31:0]          rsp_data    [2];
    logic                 sqrt_en     [2];
    logic [31:0]          sqrt_a      [2];
    logic [31:0]          sqrt_result [2];

    always #5 clk = ~clk;

    fsqrt_arbiter #(.N_REQ(N_REQ), .SQRT_LAT(SQRT_LAT), .PIPELINED(1)) dut_pipe (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_data(req_data[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
        .rsp_data(rsp_data[0]), .sqrt_en(sqrt_en[0]), .sqrt_a(sqrt_a[0]),
        .sqrt_result(sqrt_result[0])
    );

    fsqrt_arbiter #(.N_REQ(N_REQ), .SQRT_LAT(SQRT_LAT), .PIPELINED(0)) dut_seq (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_data(req_data[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
        .rsp_data(rsp_data[1]), .sqrt_en(sqrt_en[1]), .sqrt_a(sqrt_a[1]),
        .sqrt_result(sqrt_result[1])
    );

    // Stand-in square-root unit: exact for the table, an arbitrary mapping otherwise
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        case (a)
            32'h41C80000: return 32'h40A00000;
            32'h41800000: return 32'h40800000;
            32'h42C80000: return 32'h41200000;
            32'h3F800000: return 32'h3F800000;
            32'h40800000: return 32'h40000000;
            32'h80000000: return 32'h80000000;
            default:      return a ^ 32'h1234_5678;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        always @(posedge clk) begin
            if (sqrt_en[gi]) sqrt_result[gi] <= ref_sqrt(sqrt_a[gi]);
        end
    end

    typedef struct {
        int          inst;
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               ptr_m      [2];
    int               last_issue [2];
    logic             exp_en     [2];
    logic [31:0]      exp_a      [2];
    logic [N_REQ-1:0] xfer_last  [2];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int u = 0; u < 2; u++) begin
            ptr_m[u]      = 0;
            last_issue[u] = -100;
            exp_en[u]     = 1'b0;
            exp_a[u]      = 32'd0;
            xfer_last[u]  = '0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s.u%0d.req_ready", tag, u), 32'(req_ready[u]), 32'd0);
            chk($sformatf("%s.u%0d.rsp_valid", tag, u), 32'(rsp_valid[u]), 32'd0);
            chk($sformatf("%s.u%0d.rsp_id", tag, u),    32'(rsp_id[u]),    32'd0);
            chk($sformatf("%s.u%0d.rsp_data", tag, u),  rsp_data[u],       32'd0);
            chk($sformatf("%s.u%0d.sqrt_en", tag, u),   32'(sqrt_en[u]),   32'd0);
            chk($sformatf("%s.u%0d.sqrt_a", tag, u),    sqrt_a[u],         32'd0);
        end
    endtask

    // Arbitration rule applied to the current inputs; records any transfer
    task automatic resolve(input int u);
        int               win;
        bit               allowed;
        logic [N_REQ-1:0] want;
        logic [31:0]      op;
        bit               neg;
        allowed = (u == 0) || (cyc - last_issue[u] >= SQRT_LAT + 2);
        win = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (ptr_m[u] + k) % N_REQ;
            if (win < 0 && req_valid[u][idx]) win = idx;
        end
        want      = '0;
        exp_en[u] = 1'b0;
        if (allowed && win >= 0) begin
            want[win] = 1'b1;
            op  = req_data[u][32*win +: 32];
            neg = op[31] && (op[30:0] != 31'd0);
            exp_q.push_back('{inst: u, due: cyc + SQRT_LAT + 1, id: win,
                              data: neg ? 32'h7FC00000 : ref_sqrt(op)});
            exp_en[u]     = !neg;
            exp_a[u]      = op;
            ptr_m[u]      = (win + 1) % N_REQ;
            last_issue[u] = cyc;
        end
        chk($sformatf("u%0d.req_ready", u), 32'(req_ready[u]), 32'(want));
        xfer_last[u] = want;
    endtask

    task automatic check_outputs(input int u);
        int found;
        found = -1;
        foreach (exp_q[k]) begin
            if (found < 0 && exp_q[k].inst == u && exp_q[k].due == cyc) found = k;
        end
        chk($sformatf("u%0d.sqrt_en", u), 32'(sqrt_en[u]), 32'(exp_en[u]));
        if (exp_en[u]) chk($sformatf("u%0d.sqrt_a", u), sqrt_a[u], exp_a[u]);
        if (found >= 0) begin
            chk($sformatf("u%0d.rsp_valid", u), 32'(rsp_valid[u]), 32'd1);
            chk($sformatf("u%0d.rsp_id", u),    32'(rsp_id[u]),    32'(exp_q[found].id));
            chk($sformatf("u%0d.rsp_data", u),  rsp_data[u],       exp_q[found].data);
            $display("cycle %0d u%0d rsp id=%0d data=%h (want id=%0d data=%h)", cyc, u,
                     rsp_id[u], rsp_data[u], exp_q[found].id, exp_q[found].data);
            exp_q.delete(found);
        end else begin
            chk($sformatf("u%0d.rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic cycle();
        #1;
        resolve(0);
        resolve(1);
        @(negedge clk);
        cyc++;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic post(input int i, input logic [31:0] d);
        for (int u = 0; u < 2; u++) begin
            req_valid[u][i]         = 1'b1;
            req_data[u][32*i +: 32] = d;
        end
    endtask

    task automatic run(input int n, input bit clear);
        for (int c = 0; c < n; c++) begin
            cycle();
            if (clear) begin
                for (int u = 0; u < 2; u++)
                    for (int i = 0; i < N_REQ; i++)
                        if (xfer_last[u][i]) req_valid[u][i] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h41C80000;
            1:       return 32'h42C80000;
            2:       return {1'b1, r[30:0] | 31'd1};
            3:       return 32'h80000000;
            default: return {1'b0, r[30:0]};
        endcase
    endfunction

    task automatic drive_random();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (xfer_last[u][i]) begin
                    req_valid[u][i] = ($urandom_range(0, 1) == 1);
                    req_data[u][32*i +: 32] = rand_op();
                end else if (req_valid[u][i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[u][i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[u][i] = 1'b1;
                    req_data[u][32*i +: 32] = rand_op();
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = '0;
            req_data[u]  = '0;
        end
        model_reset();
        #2;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs(0);
        check_outputs(1);

        post(0, 32'h41C80000);                       // sqrt(25)
        run(8, 1'b1);

        post(0, 32'h41800000); post(1, 32'h42C80000);
        post(2, 32'h3F800000); post(3, 32'h40800000);
        run(12, 1'b0);                               // all four held valid
        for (int u = 0; u < 2; u++) req_valid[u] = '0;
        run(8, 1'b1);

        post(2, 32'hC0800000);                       // -4 bypasses the unit
        run(8, 1'b1);
        post(1, 32'h80000000);                       // -0.0 goes to the unit
        run(8, 1'b1);
        post(0, 32'h41C80000); post(1, 32'h42C80000);
        run(12, 1'b1);

        post(0, 32'h41800000); post(1, 32'h42C80000);
        post(2, 32'h3F800000); post(3, 32'h40800000);
        run(2, 1'b1);
        for (int u = 0; u < 2; u++) req_valid[u] = '1;
        #2 rst_n = 1'b0;
        #1 check_reset("mid");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs(0);
        check_outputs(1);
        run(10, 1'b1);

        for (int c = 0; c < 1500; c++) begin
            cycle();
            drive_random();
        end
        for (int u = 0; u < 2; u++) req_valid[u] = '0;
        run(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
